// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared constants, FSM state encoding and the one-hot helper for the
// 16-channel round-robin mux scheduler.
package mux16_rr_scheduler_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot16(input logic [SEL_W-1:0] idx);
        onehot16 = NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// found by rotating the request vector, priority-encoding, then un-rotating.
module rr_pick16
    import mux16_rr_scheduler_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_idx,
    output logic              o_any
);

    logic [NUM_CH-1:0] w_rot;
    logic [SEL_W-1:0]  w_off;

    // Rotate so that bit 0 of w_rot is the channel currently holding priority.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_rot[i] = i_req[SEL_W'(i) + i_ptr];
        end
    end

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        w_off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_off = w_rot[i] ? SEL_W'(i) : w_off;
        end
    end

    assign o_idx = w_off + i_ptr;
    assign o_any = |i_req;

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin select generator for a 16:1 byte mux, with a capture register
// and valid/ready output handshake behind the mux.
module mux16_rr_scheduler
    import mux16_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [SEL_W-1:0]  select,
    input  logic [DATA_W-1:0] muxData,
    output logic [NUM_CH-1:0] ack,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic [SEL_W-1:0]  outChan
);

    state_e            r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_select;
    logic [SEL_W-1:0]  r_chan;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [NUM_CH-1:0] r_ack;

    logic [SEL_W-1:0]  w_idx;
    logic              w_any;

    rr_pick16 u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Scheduler FSM; r_select doubles as the committed grant index until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 4'd0;
            r_select <= 4'd0;
            r_chan   <= 4'd0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ack    <= 16'd0;
        end else begin
            r_ack <= 16'd0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_select <= w_idx;
                        r_chan   <= w_idx;
                        r_state  <= SELECT;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SELECT: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_data  <= muxData;
                    r_valid <= 1'b1;
                    r_ack   <= onehot16(r_select);
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (r_valid && outReady) begin
                        r_valid <= 1'b0;
                        r_ptr   <= r_select + 4'd1;
                        r_state <= IDLE;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign select   = r_select;
    assign outChan  = r_chan;
    assign outData  = r_data;
    assign outValid = r_valid;
    assign ack      = r_ack;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed and randomized bench for mux16_rr_scheduler with a transaction-level
// round-robin model and a behavioural 16:1 mux feeding muxData.
module tb_mux16_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [3:0]  select;
    logic [7:0]  muxData;
    logic [15:0] ack;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic [3:0]  outChan;

    logic [7:0]  chan_data [16];
    int          checks;
    int          failures;
    int          mptr;

    mux16_rr_scheduler #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .select   (select),
        .muxData  (muxData),
        .ack      (ack),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outChan  (outChan)
    );

    assign muxData = chan_data[select];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference arbitration: first requesting channel scanning from ptr upward, modulo 16.
    function automatic int model_pick(input logic [15:0] r, input int p);
        model_pick = -1;
        for (int k = 0; k < 16; k++) begin
            if (model_pick < 0 && r[(p + k) % 16]) model_pick = (p + k) % 16;
        end
    endfunction

    task automatic do_txn(input logic [15:0] r, input int stall, input bit drop);
        int         w;
        logic [7:0] d;
        w = model_pick(r, mptr);
        d = chan_data[w];
        req = r;
        outReady = 1'($urandom);
        tick();
        chk("grant_select", 32'(select), 32'(w));
        chk("grant_no_valid", 32'(outValid), 32'd0);
        chk("grant_no_ack", 32'(ack), 32'd0);
        if (drop) req = 16'd0;
        tick();
        chk("settle_no_ack", 32'(ack), 32'd0);
        chk("settle_no_valid", 32'(outValid), 32'd0);
        tick();
        chk("cap_ack", 32'(ack), 32'(16'd1 << w));
        chk("cap_data", 32'(outData), 32'(d));
        chk("cap_chan", 32'(outChan), 32'(w));
        chk("cap_valid", 32'(outValid), 32'd1);
        req = 16'd0;
        outReady = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("hold_valid", 32'(outValid), 32'd1);
            chk("hold_data", 32'(outData), 32'(d));
            chk("hold_select", 32'(select), 32'(w));
            chk("hold_chan", 32'(outChan), 32'(w));
            chk("hold_no_ack", 32'(ack), 32'd0);
        end
        outReady = 1'b1;
        tick();
        chk("xfer_valid_clr", 32'(outValid), 32'd0);
        chk("xfer_no_ack", 32'(ack), 32'd0);
        mptr = (w + 1) % 16;
    endtask

    initial begin
        logic [15:0] r;
        checks   = 0;
        failures = 0;
        mptr     = 0;
        for (int c = 0; c < 16; c++) chan_data[c] = 8'(c * 17 + 3);
        rst      = 1'b1;
        req      = 16'hFFFF;
        outReady = 1'b1;

        // Reset held with all requests active
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_select", 32'(select), 32'd0);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_valid", 32'(outValid), 32'd0);
            chk("rst_data", 32'(outData), 32'd0);
            chk("rst_chan", 32'(outChan), 32'd0);
        end
        rst = 1'b0;
        req = 16'd0;
        tick();
        chk("idle_select", 32'(select), 32'd0);
        chk("idle_valid", 32'(outValid), 32'd0);

        // Single request on channel 5, then ptr should favour channel 6 over 0
        chan_data[5] = 8'hA5;
        do_txn(16'h0020, 0, 1'b0);
        tick();
        chk("idle_keeps_select", 32'(select), 32'd5);
        do_txn(16'h0041, 0, 1'b0);

        // Wrap: move ptr to 14, then hold C001
        do_txn(16'h2000, 0, 1'b0);
        for (int k = 0; k < 6; k++) do_txn(16'hC001, 0, 1'b0);

        // Backpressure and withdrawn request
        do_txn(16'h0200, 10, 1'b0);
        do_txn(16'h0100, 0, 1'b1);

        // Reset during HOLD discards the byte and clears ptr
        do_txn(16'h0001, 0, 1'b0);
        req = 16'h0002;
        outReady = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_cap_ack", 32'(ack), 32'h0002);
        chk("mid_cap_valid", 32'(outValid), 32'd1);
        req = 16'd0;
        tick();
        chk("mid_hold_valid", 32'(outValid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(outValid), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_select", 32'(select), 32'd0);
        chk("mid_rst_chan", 32'(outChan), 32'd0);
        chk("mid_rst_data", 32'(outData), 32'd0);
        rst = 1'b0;
        mptr = 0;
        do_txn(16'h0003, 0, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < 16; c++) chan_data[c] = 8'($urandom);
            r = 16'($urandom);
            if (r == 16'd0) r = 16'd1 << $urandom_range(15, 0);
            do_txn(r, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
